// File: rtl/serial_borrow_lookahead_subtractor.sv
// Multi-cycle subtractor: a - b - bin computed CHUNK bits per clock, with
// the chunk borrow carried in a register between cycles.

module serial_borrow_lookahead_cell (
  input  logic ai,
  input  logic bi,
  input  logic brw_in,
  output logic d,
  output logic brw_out
);
  logic g, p;
  assign g       = ~ai & bi;
  assign p       = ~(ai ^ bi);
  assign brw_out = g | (p & brw_in);
  assign d       = ai ^ bi ^ brw_in;
endmodule

module serial_borrow_lookahead_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, res, res_nx;
  logic             brw;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] ca, cb, cd;
  logic [CHUNK:0]   bc;
  int               base;
  logic             last, accept;

  assign base   = int'(k) * CHUNK;
  assign ca     = a_q[base +: CHUNK];
  assign cb     = b_q[base +: CHUNK];
  assign last   = (base == WIDTH - CHUNK);
  // start is only honoured outside RUN, so DONE can chain straight into the next op
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign bc[0]  = brw;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    serial_borrow_lookahead_cell u_cell (
      .ai     (ca[i]),
      .bi     (cb[i]),
      .brw_in (bc[i]),
      .d      (cd[i]),
      .brw_out(bc[i+1])
    );
  end

  always_comb begin
    res_nx = res;
    res_nx[base +: CHUNK] = cd;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      brw      <= 1'b0;
      k        <= '0;
      res      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      brw <= bin;
      k   <= '0;
      res <= '0;
    end else if (state == RUN) begin
      res <= res_nx;
      brw <= bc[CHUNK];
      k   <= k + 1'b1;
      // outputs only ever see the fully assembled result
      if (last) begin
        diff     <= res_nx;
        bout     <= bc[CHUNK];
        overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_serial_borrow_lookahead_subtractor.sv
// Scoreboard bench: expected results queued at launch, popped when done pulses.
module tb_serial_borrow_lookahead_subtractor;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
  localparam int LAT   = N + 1; // negedges from driving start to seeing done

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, bout, overflow;
  logic [31:0] diff;

  res_t exp_q[$];
  int   total = 0, passed = 0;

  serial_borrow_lookahead_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] f;
    res_t r;
    f    = {1'b0, x} - {1'b0, y} - {32'b0, c};
    r.d  = f[31:0];
    r.bo = f[32];
    r.ov = (x[31] != y[31]) && (f[31] != x[31]);
    return r;
  endfunction

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic c);
    a = x; b = y; bin = c; start = 1'b1;
    exp_q.push_back(model(x, y, c));
    @(negedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; bin = ~c;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    lat = 1; bcyc = 0;
    while (!done && lat < 20) begin
      if (busy) bcyc++;
      @(negedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (diff !== 32'h0) $display("FAIL reset_diff got %h want 0", diff); else passed++;
    total++; if ({busy, done, bout, overflow} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, bout, overflow}); else passed++;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if ({busy, done} !== 2'b0) $display("FAIL idle_flags got %b want 00", {busy, done}); else passed++;
  endtask

  task automatic test_basic();
    int lat, bc;
    res_t e;
    launch(32'd5, 32'd3, 1'b0);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    total++; if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if (bc !== N) $display("FAIL basic_busy_cycles got %0d want %0d", bc, N); else passed++;
    total++; if (diff !== 32'h2) $display("FAIL basic_diff got %h want 00000002", diff); else passed++;
    total++; if ({bout, overflow} !== {e.bo, e.ov}) $display("FAIL basic_flags got %b want %b", {bout, overflow}, {e.bo, e.ov}); else passed++;
    @(negedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
    repeat (3) @(negedge clk); #1;
    total++; if (diff !== e.d) $display("FAIL basic_hold got %h want %h", diff, e.d); else passed++;
  endtask

  task automatic test_boundaries();
    logic [64:0] tbl [5];
    int lat, bc;
    res_t e;
    tbl[0] = {32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[1] = {32'h8000_0000, 32'h0000_0001, 1'b0};
    tbl[2] = {32'h0000_0100, 32'h0000_0001, 1'b1};
    tbl[3] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = {32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      launch(tbl[i][64:33], tbl[i][32:1], tbl[i][0]);
      wait_done(lat, bc);
      e = exp_q.pop_front();
      total++; if (lat !== LAT) $display("FAIL bound%0d_latency got %0d want %0d", i, lat, LAT); else passed++;
      total++; if ({diff, bout, overflow} !== {e.d, e.bo, e.ov})
        $display("FAIL bound%0d_result got %h/%b/%b want %h/%b/%b", i, diff, bout, overflow, e.d, e.bo, e.ov);
      else passed++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_start_during_run();
    int dc = 0;
    res_t e, got;
    got = '0;
    launch(32'h1234_5678, 32'h0000_1111, 1'b0);
    @(negedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin dc++; got = '{diff, bout, overflow}; end
      @(negedge clk); #1;
    end
    e = exp_q.pop_front();
    total++; if (dc !== 1) $display("FAIL run_ignore_done_count got %0d want 1", dc); else passed++;
    total++; if (got !== e) $display("FAIL run_ignore_result got %h want %h", got, e); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    res_t e;
    a = 32'd100; b = 32'd1; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(32'd100, 32'd1, 1'b0));
    @(negedge clk); #1;
    a = 32'd10; b = 32'd20;
    exp_q.push_back(model(32'd10, 32'd20, 1'b0));
    wait_done(lat, bc);
    e = exp_q.pop_front();
    total++; if (lat !== LAT || bc !== N) $display("FAIL b2b_first_timing got %0d/%0d want %0d/%0d", lat, bc, LAT, N); else passed++;
    total++; if ({diff, bout} !== {e.d, e.bo}) $display("FAIL b2b_first_result got %h/%b want %h/%b", diff, bout, e.d, e.bo); else passed++;
    @(negedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept got %b want 10", {busy, done}); else passed++;
    wait_done(lat, bc);
    e = exp_q.pop_front();
    total++; if (lat !== LAT) $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if ({diff, bout} !== {32'hFFFF_FFF6, 1'b1}) $display("FAIL b2b_second_result got %h/%b want fffffff6/1", diff, bout); else passed++;
    total++; if (overflow !== e.ov) $display("FAIL b2b_second_ovf got %b want %b", overflow, e.ov); else passed++;
    @(negedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int dc = 0, lat, bc;
    res_t e;
    launch(32'h1234_5678, 32'h0000_0001, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({diff, bout, overflow} !== 34'b0) $display("FAIL abort_outputs got %h/%b/%b want 0/0/0", diff, bout, overflow); else passed++;
    total++; if ({busy, done} !== 2'b0) $display("FAIL abort_flags got %b want 00", {busy, done}); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      if (done) dc++;
    end
    total++; if (dc !== 0) $display("FAIL abort_no_done got %0d want 0", dc); else passed++;
    launch(32'd7, 32'd7, 1'b0);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    total++; if (lat !== LAT) $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if ({diff, bout, overflow} !== {e.d, e.bo, e.ov}) $display("FAIL post_reset_result got %h/%b/%b want %h/%b/%b", diff, bout, overflow, e.d, e.bo, e.ov); else passed++;
    @(negedge clk); #1;
  endtask

  task automatic test_random();
    int lat, bc;
    res_t e, prev;
    prev = '{32'h0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      launch($urandom, $urandom, 1'($urandom_range(0, 1)));
      total++; if ({diff, bout, overflow} !== {prev.d, prev.bo, prev.ov}) $display("FAIL rnd%0d_hold got %h want %h", i, diff, prev.d); else passed++;
      wait_done(lat, bc);
      e = exp_q.pop_front();
      total++; if ({diff, bout, overflow} !== {e.d, e.bo, e.ov})
        $display("FAIL rnd%0d_result got %h/%b/%b want %h/%b/%b", i, diff, bout, overflow, e.d, e.bo, e.ov);
      else passed++;
      prev = e;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_start_during_run();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
